// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: accumulates coin credit, arbitrates selection/cancel/timeout,
// tracks per-item stock, drives the dispenser handshake and returns change one unit at a time.
module vend_txn_ctrl #(
  parameter int PRICE1      = 3,
  parameter int PRICE2      = 5,
  parameter int PRICE3      = 7,
  parameter int CREDIT_MAX  = 31,
  parameter int STOCK_INIT  = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [3:0] coin_val,
  input  logic       sel_valid,
  input  logic [1:0] sel,
  input  logic       cancel,
  input  logic       refill,
  output logic       disp_req,
  output logic [1:0] disp_item,
  input  logic       disp_ack,
  output logic       chg_valid,
  input  logic       chg_ready,
  output logic [5:0] credit,
  output logic       busy,
  output logic       coin_reject,
  output logic       insufficient_money,
  output logic       sold_out
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CREDIT   = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [5:0]    credit_s;
  logic [3:0]    stock_r [4];
  logic [3:0]    stock_s [4];
  logic [TW-1:0] tmo_r;
  logic [TW-1:0] tmo_s;
  logic [TW-1:0] tmo_inc_s;
  logic [1:0]    item_s;
  logic [6:0]    sum_s;
  logic [5:0]    price_s;
  logic          xfer_s;
  logic          coin_rej_s;
  logic          insuf_s;
  logic          sold_s;
  logic          disp_req_s;
  logic          chg_valid_s;
  logic          busy_s;

  function automatic logic [5:0] price_of(input logic [1:0] s);
    case (s)
      2'b01:   price_of = 6'(PRICE1);
      2'b10:   price_of = 6'(PRICE2);
      2'b11:   price_of = 6'(PRICE3);
      default: price_of = 6'd0;
    endcase
  endfunction

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r            <= S_IDLE;
      credit             <= 6'd0;
      tmo_r              <= {TW{1'b0}};
      disp_item          <= 2'b00;
      disp_req           <= 1'b0;
      chg_valid          <= 1'b0;
      busy               <= 1'b0;
      coin_reject        <= 1'b0;
      insufficient_money <= 1'b0;
      sold_out           <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        stock_r[i] <= 4'(STOCK_INIT);
      end
    end else begin
      state_r            <= state_s;
      credit             <= credit_s;
      tmo_r              <= tmo_s;
      disp_item          <= item_s;
      disp_req           <= disp_req_s;
      chg_valid          <= chg_valid_s;
      busy               <= busy_s;
      coin_reject        <= coin_rej_s;
      insufficient_money <= insuf_s;
      sold_out           <= sold_s;
      for (int i = 0; i < 4; i++) begin
        stock_r[i] <= stock_s[i];
      end
    end
  end

  // Next-state and datapath decode with event arbitration
  always_comb begin
    state_s    = state_r;
    credit_s   = credit;
    tmo_s      = tmo_r;
    item_s     = disp_item;
    coin_rej_s = 1'b0;
    insuf_s    = 1'b0;
    sold_s     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stock_s[i] = stock_r[i];
    end
    // Sum kept one bit wider so an overflowing coin is caught before the compare
    sum_s     = {1'b0, credit} + {3'b000, coin_val};
    price_s   = price_of(sel);
    tmo_inc_s = tmo_r + TW'(1);
    xfer_s    = chg_valid & chg_ready;

    case (state_r)
      S_IDLE: begin
        tmo_s = {TW{1'b0}};
        if (coin_valid && (coin_val != 4'd0) && (sum_s <= 7'(CREDIT_MAX))) begin
          credit_s = sum_s[5:0];
          state_s  = S_CREDIT;
        end else begin
          credit_s = credit;
          state_s  = S_IDLE;
        end
        coin_rej_s = coin_valid && (coin_val != 4'd0) && (sum_s > 7'(CREDIT_MAX));
        insuf_s    = sel_valid && (sel != 2'b00);
        for (int i = 0; i < 4; i++) begin
          stock_s[i] = refill ? 4'(STOCK_INIT) : stock_r[i];
        end
      end

      S_CREDIT: begin
        if (cancel) begin
          coin_rej_s = coin_valid;
          tmo_s      = {TW{1'b0}};
          state_s    = S_CHANGE;
        end else if (sel_valid) begin
          coin_rej_s = coin_valid;
          tmo_s      = {TW{1'b0}};
          if (sel == 2'b00) begin
            state_s = S_CREDIT;
          end else if (stock_r[sel] == 4'd0) begin
            sold_s = 1'b1;
          end else if (credit < price_s) begin
            insuf_s = 1'b1;
          end else begin
            credit_s     = credit - price_s;
            stock_s[sel] = stock_r[sel] - 4'd1;
            item_s       = sel;
            state_s      = S_DISPENSE;
          end
        end else if (coin_valid) begin
          tmo_s = {TW{1'b0}};
          if (sum_s > 7'(CREDIT_MAX)) begin
            coin_rej_s = 1'b1;
          end else begin
            credit_s = sum_s[5:0];
          end
        end else if (tmo_inc_s == TW'(TIMEOUT_CYC)) begin
          tmo_s   = {TW{1'b0}};
          state_s = S_CHANGE;
        end else begin
          tmo_s = tmo_inc_s;
        end
      end

      S_DISPENSE: begin
        coin_rej_s = coin_valid;
        if (disp_ack) begin
          item_s  = 2'b00;
          state_s = (credit != 6'd0) ? S_CHANGE : S_IDLE;
        end else begin
          state_s = S_DISPENSE;
        end
      end

      S_CHANGE: begin
        coin_rej_s = coin_valid;
        if (credit == 6'd0) begin
          state_s = S_IDLE;
        end else if (xfer_s) begin
          credit_s = credit - 6'd1;
          state_s  = (credit == 6'd1) ? S_IDLE : S_CHANGE;
        end else begin
          state_s = S_CHANGE;
        end
      end

      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state, registered alongside it
  always_comb begin
    disp_req_s  = (state_s == S_DISPENSE);
    chg_valid_s = (state_s == S_CHANGE) && (credit_s != 6'd0);
    busy_s      = (state_s != S_IDLE);
  end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Self-checking bench for vend_txn_ctrl: directed vector table, multi-cycle corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_vend_txn_ctrl;
  localparam int PRICE1      = 3;
  localparam int PRICE2      = 5;
  localparam int PRICE3      = 7;
  localparam int CREDIT_MAX  = 31;
  localparam int STOCK_INIT  = 4;
  localparam int TIMEOUT_CYC = 1000;

  logic       clk;
  logic       rst;
  logic       coin_valid;
  logic [3:0] coin_val;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       refill;
  logic       disp_req;
  logic [1:0] disp_item;
  logic       disp_ack;
  logic       chg_valid;
  logic       chg_ready;
  logic [5:0] credit;
  logic       busy;
  logic       coin_reject;
  logic       insufficient_money;
  logic       sold_out;

  vend_txn_ctrl #(
    .PRICE1(PRICE1), .PRICE2(PRICE2), .PRICE3(PRICE3),
    .CREDIT_MAX(CREDIT_MAX), .STOCK_INIT(STOCK_INIT), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_val(coin_val),
    .sel_valid(sel_valid), .sel(sel),
    .cancel(cancel), .refill(refill),
    .disp_req(disp_req), .disp_item(disp_item), .disp_ack(disp_ack),
    .chg_valid(chg_valid), .chg_ready(chg_ready),
    .credit(credit), .busy(busy),
    .coin_reject(coin_reject), .insufficient_money(insufficient_money), .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  // Expected word layout: {credit[13:8], busy, req, item[5:4], chg, rej, ins, sold}
  typedef struct {
    logic       cv;
    logic [3:0] cval;
    logic       sv;
    logic [1:0] sel;
    logic       can;
    logic       rfl;
    logic       ack;
    logic       rdy;
    logic [13:0] exp;
  } vec_t;

  typedef enum {P_IDLE, P_PAY, P_VEND, P_REFUND} phase_t;

  phase_t ph;
  int     m_credit;
  int     m_stock [4];
  int     m_idle;
  int     m_item;
  bit     m_chg, m_rej, m_ins, m_sold;
  int     checks = 0;
  int     errors = 0;
  vec_t   tbl [$];
  vec_t   r;
  int     units;

  function automatic vec_t mk(bit cv, int cval, bit sv, int s, bit can, bit rfl, bit ack, bit rdy);
    vec_t v;
    v.cv = cv; v.cval = 4'(cval); v.sv = sv; v.sel = 2'(s);
    v.can = can; v.rfl = rfl; v.ack = ack; v.rdy = rdy; v.exp = 14'd0;
    return v;
  endfunction

  function automatic vec_t tv(vec_t v, logic [13:0] e);
    vec_t o;
    o = v;
    o.exp = e;
    return o;
  endfunction

  function automatic logic [13:0] pk(int cr, bit bz, bit rq, int it, bit cg, bit rj, bit ins, bit so);
    return {6'(cr), bz, rq, 2'(it), cg, rj, ins, so};
  endfunction

  function automatic logic [13:0] model_exp();
    return pk(m_credit, ph != P_IDLE, ph == P_VEND, (ph == P_VEND) ? m_item : 0,
              m_chg, m_rej, m_ins, m_sold);
  endfunction

  // disp_item is only defined while a dispense is requested
  function automatic logic [13:0] obs(logic [13:0] e);
    return {credit, busy, disp_req, e[6] ? disp_item : 2'b00,
            chg_valid, coin_reject, insufficient_money, sold_out};
  endfunction

  task automatic cmp(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic model_reset();
    ph = P_IDLE; m_credit = 0; m_idle = 0; m_item = 0;
    m_chg = 1'b0; m_rej = 1'b0; m_ins = 1'b0; m_sold = 1'b0;
    for (int i = 0; i < 4; i++) m_stock[i] = STOCK_INIT;
  endtask

  task automatic model_step(input vec_t v);
    int price;
    bit xfer;
    xfer = m_chg && v.rdy;
    m_rej = 1'b0; m_ins = 1'b0; m_sold = 1'b0;
    price = (v.sel == 2'd1) ? PRICE1 : (v.sel == 2'd2) ? PRICE2 : (v.sel == 2'd3) ? PRICE3 : 0;
    case (ph)
      P_IDLE: begin
        if (v.cv && v.cval != 4'd0) begin
          if (m_credit + int'(v.cval) > CREDIT_MAX) m_rej = 1'b1;
          else begin m_credit += int'(v.cval); ph = P_PAY; m_idle = 0; end
        end
        if (v.sv && v.sel != 2'd0) m_ins = 1'b1;
        if (v.rfl) for (int i = 1; i <= 3; i++) m_stock[i] = STOCK_INIT;
      end
      P_PAY: begin
        if (v.can) begin
          m_rej = v.cv; ph = P_REFUND;
        end else if (v.sv) begin
          m_rej = v.cv; m_idle = 0;
          if (v.sel == 2'd0) begin
          end else if (m_stock[v.sel] == 0) m_sold = 1'b1;
          else if (m_credit < price) m_ins = 1'b1;
          else begin
            m_credit -= price; m_stock[v.sel]--; m_item = int'(v.sel); ph = P_VEND;
          end
        end else if (v.cv) begin
          m_idle = 0;
          if (m_credit + int'(v.cval) > CREDIT_MAX) m_rej = 1'b1;
          else m_credit += int'(v.cval);
        end else begin
          m_idle++;
          if (m_idle == TIMEOUT_CYC) ph = P_REFUND;
        end
      end
      P_VEND: begin
        m_rej = v.cv;
        if (v.ack) ph = (m_credit > 0) ? P_REFUND : P_IDLE;
      end
      P_REFUND: begin
        m_rej = v.cv;
        if (xfer) m_credit--;
        if (m_credit == 0) ph = P_IDLE;
      end
      default: ph = P_IDLE;
    endcase
    m_chg = (ph == P_REFUND) && (m_credit > 0);
  endtask

  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    coin_valid = v.cv; coin_val = v.cval; sel_valid = v.sv; sel = v.sel;
    cancel = v.can; refill = v.rfl; disp_ack = v.ack; chg_ready = v.rdy;
    @(posedge clk);
    model_step(v);
    #1;
    cmp(name, obs(model_exp()), model_exp());
  endtask

  task automatic drain(input string name, output int n);
    n = 0;
    while (ph != P_IDLE && n < 64) begin
      step(mk(0, 0, 0, 0, 0, 0, 0, 1), name);
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; rst = 1'b1;
    coin_valid = 1'b0; coin_val = 4'd0; sel_valid = 1'b0; sel = 2'b00;
    cancel = 1'b0; refill = 1'b0; disp_ack = 1'b0; chg_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_state", {credit, busy, disp_req, disp_item, chg_valid, coin_reject,
                        insufficient_money, sold_out}, 14'd0);
    @(negedge clk);
    rst = 1'b0;

    // Coins 2,2, buy item 1, one change unit; insufficient then cancel refund; overflow reject
    tbl.push_back(tv(mk(1, 2, 0, 0, 0, 0, 0, 0), pk(2, 1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(tv(mk(1, 2, 0, 0, 0, 0, 0, 0), pk(4, 1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(tv(mk(0, 0, 1, 1, 0, 0, 0, 0), pk(1, 1, 1, 1, 0, 0, 0, 0)));
    tbl.push_back(tv(mk(0, 0, 0, 0, 0, 0, 0, 0), pk(1, 1, 1, 1, 0, 0, 0, 0)));
    tbl.push_back(tv(mk(0, 0, 0, 0, 0, 0, 1, 0), pk(1, 1, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(tv(mk(0, 0, 0, 0, 0, 0, 0, 1), pk(0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(tv(mk(0, 0, 0, 0, 0, 0, 0, 0), pk(0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(tv(mk(1, 4, 0, 0, 0, 0, 0, 0), pk(4, 1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(tv(mk(0, 0, 1, 3, 0, 0, 0, 0), pk(4, 1, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(tv(mk(0, 0, 0, 0, 1, 0, 0, 1), pk(4, 1, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(tv(mk(0, 0, 0, 0, 0, 0, 0, 1), pk(3, 1, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(tv(mk(0, 0, 0, 0, 0, 0, 0, 1), pk(2, 1, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(tv(mk(0, 0, 0, 0, 0, 0, 0, 1), pk(1, 1, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(tv(mk(0, 0, 0, 0, 0, 0, 0, 1), pk(0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(tv(mk(1, 0, 0, 0, 1, 0, 1, 1), pk(0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(tv(mk(1, 15, 0, 0, 0, 0, 0, 0), pk(15, 1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(tv(mk(1, 15, 0, 0, 0, 0, 0, 0), pk(30, 1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(tv(mk(1, 5, 0, 0, 0, 0, 0, 0), pk(30, 1, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(tv(mk(1, 1, 0, 0, 0, 0, 0, 0), pk(31, 1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(tv(mk(0, 0, 0, 0, 1, 0, 0, 0), pk(31, 1, 0, 0, 1, 0, 0, 0)));
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("tbl%0d_model", i));
      cmp($sformatf("tbl%0d", i), obs(tbl[i].exp), tbl[i].exp);
    end
    drain("refund31", units);
    cmp("refund31_units", 14'(units), 14'd31);

    // Exhaust item 2, sold_out on the fifth buy, refund, refill restores stock
    for (int k = 0; k < 4; k++) begin
      step(mk(1, 5, 0, 0, 0, 0, 0, 0), "buy2_coin");
      step(mk(0, 0, 1, 2, 0, 0, 0, 0), "buy2_sel");
      cmp("buy2_req", {12'd0, disp_item}, 14'd2);
      step(mk(0, 0, 0, 0, 0, 0, 1, 0), "buy2_ack");
      cmp("buy2_idle", {13'd0, busy}, 14'd0);
    end
    step(mk(1, 5, 0, 0, 0, 0, 0, 0), "sold_coin");
    step(mk(0, 0, 1, 2, 0, 0, 0, 0), "sold_sel");
    cmp("sold_out_pulse", {disp_req, 12'd0, sold_out}, 14'd1);
    cmp("sold_credit", {8'd0, credit}, 14'd5);
    step(mk(0, 0, 0, 0, 1, 0, 0, 0), "sold_cancel");
    drain("sold_refund", units);
    cmp("sold_refund_units", 14'(units), 14'd5);
    step(mk(0, 0, 0, 0, 0, 1, 0, 0), "refill");
    step(mk(1, 5, 0, 0, 0, 0, 0, 0), "refill_coin");
    step(mk(0, 0, 1, 2, 0, 0, 0, 0), "refill_sel");
    cmp("refill_restock", {13'd0, disp_req}, 14'd1);
    step(mk(0, 0, 0, 0, 0, 0, 1, 0), "refill_ack");

    // Selection and coin in the same cycle: item vended, coin refused, nothing owed
    step(mk(1, 3, 0, 0, 0, 0, 0, 0), "same_coin");
    step(mk(1, 4, 1, 1, 0, 0, 0, 0), "same_sel");
    cmp("same_cycle", {credit, disp_req, coin_reject}, {6'd0, 8'b0000_0011});
    step(mk(0, 0, 0, 0, 0, 0, 1, 0), "same_ack");
    cmp("same_no_change", {12'd0, chg_valid, busy}, 14'd0);

    // Timeout refund, then asynchronous reset in the middle of change return
    step(mk(1, 6, 0, 0, 0, 0, 0, 0), "tmo_coin");
    for (int k = 0; k < TIMEOUT_CYC - 1; k++) step(mk(0, 0, 0, 0, 0, 0, 0, 0), "tmo_wait");
    cmp("tmo_before", {12'd0, chg_valid, busy}, 14'd1);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0), "tmo_fire");
    cmp("tmo_fired", {credit, 7'd0, chg_valid}, {6'd6, 8'd1});
    step(mk(0, 0, 0, 0, 0, 0, 0, 1), "tmo_chg1");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1), "tmo_chg2");
    @(negedge clk);
    coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; refill = 1'b0;
    disp_ack = 1'b0; chg_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    cmp("async_rst", {credit, busy, disp_req, disp_item, chg_valid, coin_reject,
                      insufficient_money, sold_out}, 14'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      r = mk(($urandom_range(0, 9) < 3),
             ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 6)),
             ($urandom_range(0, 9) < 2), int'($urandom_range(0, 3)),
             ($urandom_range(0, 29) == 0), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
      step(r, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
